axi_stream_zigzag_row_feeder: RTL and testbench
===============================================

// Module: axi_stream_zigzag_row_feeder
// PURPOSE
//  Source-side companion to the wide 1R1C IDCT AXI-stream wrapper.
//  - Accepts one coefficient per beat in JPEG/MPEG zigzag scan order (64 beats per block).
//  - Reorders each block into raster order in a ping-pong buffer.
//  - Emits each block as 8 row beats, WIN*8 bits wide, on a master stream that feeds the IDCT slave port.
//  - Input of block N+1 overlaps output of block N.
// PARAMETERS
//  WIN  12  coefficient width in bits, signed two's complement; matches IDCT input width
// PORTS
//  clock         in   1      rising-edge clock
//  reset_n       in   1      synchronous, active-low reset
//  slave_tdata   in   WIN    one coefficient, zigzag order
//  slave_tvalid  in   1      coefficient valid
//  slave_tready  out  1      feeder can accept a coefficient
//  slave_tlast   in   1      marks final coefficient of a block
//  master_tdata  out  WIN*8  one raster row; column 0 in [8*WIN-1:7*WIN], column 7 in [WIN-1:0]
//  master_tvalid out  1      row valid
//  master_tready in   1      IDCT accepts row
//  master_tlast  out  1      high with row 7 of a block
//  err_framing   out  1      one-cycle pulse on a tlast/count mismatch
// BEHAVIOUR
//  Single clock domain. Reset is synchronous and active-low on clock.
//  Reset, and reset asserted mid-operation:
//   - Both banks are zeroed and marked EMPTY; wr_bank=0, rd_bank=0, k=0, row=0.
//   - master_tvalid=0, master_tlast=0, err_framing=0, slave_tready=1 in the first cycle after reset.
//   - Partially written or partially drained blocks are discarded.
//  Storage: two banks of 64 x WIN registers, with one state per bank: EMPTY / FILLING / FULL.
//  Write side:
//   - slave_tready = (state[wr_bank] != FULL), a registered flag.
//   - On a slave handshake: bank[wr_bank][ZZ[k]] <= slave_tdata; k increments.
//   - ZZ is the standard 8x8 zigzag-to-raster table (ZZ[0..9] = 0,1,8,16,9,2,3,10,17,24; ZZ[63]=63).
//   - Block closes on the handshake where (k==63 || slave_tlast): bank becomes FULL, k<=0, wr_bank toggles.
//   - Early tlast (k<63): close the block early; raster positions not written stay 0; err_framing pulses.
//   - k==63 without tlast: close the block normally; err_framing pulses.
//   - If the new wr_bank is still FULL, slave_tready drops until the reader releases that bank.
//  Read side:
//   - master_tvalid = (state[rd_bank] == FULL).
//   - master_tdata = row `row` of bank[rd_bank], driven combinationally from the registers.
//   - master_tlast = master_tvalid && row==7.
//   - master_tdata and master_tlast are held stable while tvalid && !tready.
//   - Each handshake increments row.
//   - Handshake on row 7: bank zeroed, state EMPTY, row<=0, rd_bank toggles.
//  Latency: the first row is valid on the cycle after the handshake that closes the block.
//  Throughput: 1 coefficient/cycle input, sustained indefinitely, whenever master_tready is high at least 8 of every 64 cycles.
//  Simultaneous events:
//   - Writer closing one bank while the reader releases the other: both take effect; no stall.
//   - Reader releasing the bank the writer is blocked on: slave_tready=1 on the next cycle, with no beat lost or duplicated.
//  Arithmetic: none. Coefficients are copied bit-exact, with no sign extension or saturation.
// TESTING
//  1. Feed coefficient value = zigzag index k (0..63), tlast on k=63, master_tready=1
//     -> row 0 = {0,1,5,6,14,15,27,28}; row 7 = {35,36,48,49,57,58,62,63};
//        master_tlast only on row 7; first tvalid 1 cycle after beat 63.
//  2. Send 3 back-to-back blocks with tvalid held 1 and tready=1
//     -> slave_tready never drops; 24 rows out, in order; all data bit-exact.
//  3. Hold master_tready=0; send 2 blocks
//     -> 128 beats accepted, then slave_tready=0; row 0 of block 1 held stable;
//        release tready -> 8 rows, then slave_tready=1 on the following cycle.
//  4. Send tlast at k=9 with values 1..10
//     -> err_framing pulses once; raster positions ZZ[0..9] hold 1..10, all others 0;
//        the next block is unaffected.
//  5. Send 64 beats with no tlast
//     -> err_framing pulses on beat 63; the block is emitted normally.
//  6. Assert reset_n=0 at row 3 of output while input is at k=20
//     -> next cycle master_tvalid=0, slave_tready=1; the next full block emits correctly with no stale data.

Source files
------------

// File: rtl/axi_stream_zigzag_row_feeder.sv
// Zigzag-to-raster reorder feeder: one coefficient per beat in, one 8-wide raster row per beat out.
// Two ping-pong banks let block N+1 fill while block N drains.
//
// bank state | meaning
// EMPTY      | bank zeroed, waiting for its first coefficient
// FILLING    | writer has stored at least one coefficient of the current block
// FULL       | block closed, reader owns the bank until row 7 is accepted
module axi_stream_zigzag_row_feeder #(
  parameter int WIN = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIN-1:0]     slave_tdata,
  input  logic               slave_tvalid,
  output logic               slave_tready,
  input  logic               slave_tlast,
  output logic [WIN*8-1:0]   master_tdata,
  output logic               master_tvalid,
  input  logic               master_tready,
  output logic               master_tlast,
  output logic               err_framing
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_e;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [WIN-1:0] mem_q [2][64];
  bank_st_e       state_q [2];
  bank_st_e       state_d [2];
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [5:0]     k_q, k_d;
  logic [2:0]     row_q, row_d;
  logic           tready_q, tready_d;
  logic           err_q, err_d;
  logic           wr_fire, wr_close, rd_fire, rd_done;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q[0] <= B_EMPTY;
      state_q[1] <= B_EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      k_q        <= '0;
      row_q      <= '0;
      tready_q   <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      k_q        <= k_d;
      row_q      <= row_d;
      tready_q   <= tready_d;
      err_q      <= err_d;
    end
  end

  // Writer and reader never touch the same bank: writes need !FULL, release needs FULL.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 64; i++)
          mem_q[b][i] <= '0;
    end else begin
      if (rd_done)
        for (int i = 0; i < 64; i++)
          mem_q[rd_bank_q][i] <= '0;
      if (wr_fire)
        mem_q[wr_bank_q][ZZ[k_q]] <= slave_tdata;
    end
  end

  always_comb begin
    wr_fire  = slave_tvalid && tready_q;
    wr_close = wr_fire && ((k_q == 6'd63) || slave_tlast);
    rd_fire  = master_tvalid && master_tready;
    rd_done  = rd_fire && (row_q == 3'd7);
    state_d  = state_q;
    if (wr_fire)
      state_d[wr_bank_q] = wr_close ? B_FULL : B_FILLING;
    if (rd_done)
      state_d[rd_bank_q] = B_EMPTY;
    wr_bank_d = wr_bank_q ^ wr_close;
    rd_bank_d = rd_bank_q ^ rd_done;
    k_d       = wr_close ? 6'd0 : (wr_fire ? k_q + 6'd1 : k_q);
    row_d     = rd_fire ? row_q + 3'd1 : row_q;
    // Looking at the post-update state lets a same-cycle release reopen the writer immediately.
    tready_d  = (state_d[wr_bank_d] != B_FULL);
    err_d     = wr_fire && ((k_q == 6'd63) != slave_tlast);
  end

  always_comb begin
    master_tvalid = (state_q[rd_bank_q] == B_FULL);
    master_tlast  = master_tvalid && (row_q == 3'd7);
    master_tdata  = '0;
    for (int c = 0; c < 8; c++)
      master_tdata[(7-c)*WIN +: WIN] = mem_q[rd_bank_q][{row_q, 3'(c)}];
  end

  assign slave_tready = tready_q;
  assign err_framing  = err_q;

endmodule

// File: tb/tb_axi_stream_zigzag_row_feeder.sv
// Directed bench for the zigzag row feeder: per-scenario tasks with inline checks.
module tb_axi_stream_zigzag_row_feeder;
  localparam int WIN = 12;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [WIN-1:0]   slave_tdata;
  logic             slave_tvalid;
  logic             slave_tready;
  logic             slave_tlast;
  logic [WIN*8-1:0] master_tdata;
  logic             master_tvalid;
  logic             master_tready;
  logic             master_tlast;
  logic             err_framing;

  axi_stream_zigzag_row_feeder #(.WIN(WIN)) dut (
    .clock(clock), .reset_n(reset_n),
    .slave_tdata(slave_tdata), .slave_tvalid(slave_tvalid),
    .slave_tready(slave_tready), .slave_tlast(slave_tlast),
    .master_tdata(master_tdata), .master_tvalid(master_tvalid),
    .master_tready(master_tready), .master_tlast(master_tlast),
    .err_framing(err_framing)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int stall_cnt = 0;
  logic [WIN*8-1:0] rows_q[$];
  logic [WIN*8-1:0] exp_q[$];
  bit               last_q[$];
  logic [WIN-1:0]   blk_vals [64];
  int zz_tb [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  always @(negedge clock) begin
    if (master_tvalid && master_tready) begin
      rows_q.push_back(master_tdata);
      last_q.push_back(master_tlast);
    end
    if (err_framing) err_cnt++;
    if (slave_tvalid && !slave_tready) stall_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Called and returning at posedge+1.
  task automatic send_beat(input logic [WIN-1:0] d, input bit last);
    int waitc = 0;
    slave_tdata  = d;
    slave_tlast  = last;
    slave_tvalid = 1'b1;
    @(negedge clock);
    while (!slave_tready && waitc < 2000) begin
      @(negedge clock);
      waitc++;
    end
    if (waitc >= 2000) begin
      total++; bad++;
      $display("FAIL send_timeout: slave_tready=%b required=1", slave_tready);
    end
    @(posedge clock); #1;
    slave_tvalid = 1'b0;
    slave_tlast  = 1'b0;
  endtask

  task automatic send_block(input int n, input bit use_tlast);
    logic [WIN-1:0]   ras [64];
    logic [WIN*8-1:0] row;
    for (int i = 0; i < 64; i++) ras[i] = '0;
    for (int k = 0; k < n; k++) ras[zz_tb[k]] = blk_vals[k];
    for (int r = 0; r < 8; r++) begin
      row = '0;
      for (int c = 0; c < 8; c++) row[(7-c)*WIN +: WIN] = ras[r*8+c];
      exp_q.push_back(row);
    end
    for (int k = 0; k < n; k++) send_beat(blk_vals[k], use_tlast && (k == n-1));
  endtask

  task automatic fill_vals(input int mul, input int add);
    for (int k = 0; k < 64; k++) blk_vals[k] = WIN'(k*mul + add);
  endtask

  task automatic wait_rows(input int n);
    int c = 0;
    while (rows_q.size() < n && c < 3000) begin
      @(negedge clock);
      c++;
    end
    if (c >= 3000) begin
      total++; bad++;
      $display("FAIL wait_rows: got=%0d rows required=%0d", rows_q.size(), n);
    end
    @(posedge clock); #1;
  endtask

  task automatic clear_q();
    rows_q.delete();
    last_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; master_tready = 1'b0;
    slave_tvalid = 1'b0; slave_tlast = 1'b0; slave_tdata = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    total++; if (master_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", master_tvalid); end
    total++; if (master_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", master_tlast); end
    total++; if (err_framing !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_framing); end
    total++; if (slave_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%b want=1", slave_tready); end
    @(posedge clock); #1;
  endtask

  task automatic test_zigzag_index();
    logic [WIN*8-1:0] row0_c, row7_c;
    row0_c = {12'd0, 12'd1, 12'd5, 12'd6, 12'd14, 12'd15, 12'd27, 12'd28};
    row7_c = {12'd35, 12'd36, 12'd48, 12'd49, 12'd57, 12'd58, 12'd62, 12'd63};
    clear_q();
    master_tready = 1'b1;
    fill_vals(1, 0);
    send_block(64, 1'b1);
    total++; if (rows_q.size() !== 0) begin bad++; $display("FAIL idx_early_valid rows=%0d want=0", rows_q.size()); end
    @(negedge clock);
    total++; if (master_tvalid !== 1'b1) begin bad++; $display("FAIL idx_latency tvalid=%b want=1", master_tvalid); end
    total++; if (master_tdata !== row0_c) begin bad++; $display("FAIL idx_first_row got=%h want=%h", master_tdata, row0_c); end
    @(posedge clock); #1;
    wait_rows(8);
    total++; if (rows_q[0] !== row0_c) begin bad++; $display("FAIL idx_row0 got=%h want=%h", rows_q[0], row0_c); end
    total++; if (rows_q[7] !== row7_c) begin bad++; $display("FAIL idx_row7 got=%h want=%h", rows_q[7], row7_c); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (last_q[i] !== (i == 7)) begin bad++; $display("FAIL idx_tlast row=%0d got=%b want=%b", i, last_q[i], (i == 7)); end
      total++;
      if (rows_q[i] !== exp_q[i]) begin bad++; $display("FAIL idx_rows row=%0d got=%h want=%h", i, rows_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    master_tready = 1'b1;
    stall_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      fill_vals(37 + b, 100 * b + 2048);
      send_block(64, 1'b1);
    end
    total++; if (stall_cnt !== 0) begin bad++; $display("FAIL b2b_stall cycles=%0d want=0", stall_cnt); end
    wait_rows(24);
    total++; if (rows_q.size() !== 24) begin bad++; $display("FAIL b2b_count got=%0d want=24", rows_q.size()); end
    for (int i = 0; i < 24; i++) begin
      total++;
      if (rows_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_row%0d got=%h want=%h", i, rows_q[i], exp_q[i]); end
      total++;
      if (last_q[i] !== ((i % 8) == 7)) begin bad++; $display("FAIL b2b_tlast%0d got=%b", i, last_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [WIN*8-1:0] snap;
    bit early_ready;
    clear_q();
    master_tready = 1'b0;
    stall_cnt = 0;
    fill_vals(5, 7);
    send_block(64, 1'b1);
    fill_vals(11, 3000);
    send_block(64, 1'b1);
    total++; if (stall_cnt !== 0) begin bad++; $display("FAIL bp_accept stalls=%0d want=0", stall_cnt); end
    @(negedge clock);
    total++; if (slave_tready !== 1'b0) begin bad++; $display("FAIL bp_tready_drop got=%b want=0", slave_tready); end
    total++; if (master_tdata !== exp_q[0]) begin bad++; $display("FAIL bp_row0 got=%h want=%h", master_tdata, exp_q[0]); end
    snap = master_tdata;
    repeat (5) @(negedge clock);
    total++; if (master_tdata !== snap || master_tlast !== 1'b0 || master_tvalid !== 1'b1)
      begin bad++; $display("FAIL bp_hold got=%h/%b want=%h/0", master_tdata, master_tlast, snap); end
    @(posedge clock); #1;
    master_tready = 1'b1;
    early_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (slave_tready !== 1'b0) early_ready = 1'b1;
    end
    total++; if (early_ready) begin bad++; $display("FAIL bp_early_ready got=1 want=0 during drain"); end
    @(negedge clock);
    total++; if (slave_tready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", slave_tready); end
    @(posedge clock); #1;
    wait_rows(16);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rows_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_row%0d got=%h want=%h", i, rows_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_early_tlast();
    clear_q();
    master_tready = 1'b1;
    err_cnt = 0;
    for (int k = 0; k < 64; k++) blk_vals[k] = WIN'(k + 1);
    send_block(10, 1'b1);
    @(negedge clock);
    total++; if (err_framing !== 1'b1) begin bad++; $display("FAIL early_err_pulse got=%b want=1", err_framing); end
    @(posedge clock); #1;
    fill_vals(3, 3900);
    send_block(64, 1'b1);
    wait_rows(16);
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL early_err_count got=%0d want=1", err_cnt); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rows_q[i] !== exp_q[i]) begin bad++; $display("FAIL early_row%0d got=%h want=%h", i, rows_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_no_tlast();
    clear_q();
    master_tready = 1'b1;
    err_cnt = 0;
    fill_vals(29, 1234);
    send_block(64, 1'b0);
    @(negedge clock);
    total++; if (err_framing !== 1'b1) begin bad++; $display("FAIL notlast_err_pulse got=%b want=1", err_framing); end
    @(posedge clock); #1;
    wait_rows(8);
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL notlast_err_count got=%0d want=1", err_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rows_q[i] !== exp_q[i]) begin bad++; $display("FAIL notlast_row%0d got=%h want=%h", i, rows_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    clear_q();
    master_tready = 1'b0;
    fill_vals(17, 500);
    send_block(64, 1'b1);
    for (int k = 0; k < 20; k++) send_beat(WIN'(4000 - k), 1'b0);
    master_tready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (rows_q.size() !== 3) begin bad++; $display("FAIL mrst_setup rows=%0d want=3", rows_q.size()); end
    reset_n = 1'b0;
    master_tready = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    master_tready = 1'b1;
    @(negedge clock);
    total++; if (master_tvalid !== 1'b0) begin bad++; $display("FAIL mrst_tvalid got=%b want=0", master_tvalid); end
    total++; if (slave_tready !== 1'b1) begin bad++; $display("FAIL mrst_tready got=%b want=1", slave_tready); end
    @(posedge clock); #1;
    clear_q();
    fill_vals(41, 77);
    send_block(64, 1'b1);
    wait_rows(8);
    repeat (20) @(posedge clock);
    #1;
    total++; if (rows_q.size() !== 8) begin bad++; $display("FAIL mrst_count got=%0d want=8", rows_q.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rows_q[i] !== exp_q[i]) begin bad++; $display("FAIL mrst_row%0d got=%h want=%h", i, rows_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_zigzag_index();
    test_back_to_back();
    test_backpressure();
    test_early_tlast();
    test_no_tlast();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
